stage_if_fetch: RTL and testbench
=================================

// Module: stage_if_fetch
// PURPOSE
//  Instruction-fetch stage of the ARM pipeline; feeds the IF/ID register read by the decode stage.
//  Owns the PC. Issues one-outstanding requests to a variable-latency instruction memory.
//  Honours hazard freeze from the hazard unit and branch redirect from EX.
//  Drives pcOut = fetch address + 4, instOut and validOut (registered IF/ID outputs).
// PARAMETERS
//  RESET_PC    32'h0000_0000   PC value loaded on reset
//  MAX_LAT     15              max memory latency in cycles; width of the watchdog counter
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  rst           in   1   synchronous, active-low reset
//  freeze        in   1   hazard stall: hold IF/ID outputs, issue no new request
//  branchTaken   in   1   1-cycle redirect pulse from EX
//  branchAddr    in   32  redirect target (word aligned)
//  imemReq       out  1   request strobe; memory accepts on every cycle it is high
//  imemAddr      out  32  request address, valid while imemReq=1
//  imemRvalid    in   1   response strobe, >=1 cycle after the request
//  imemRdata     in   32  instruction word, valid with imemRvalid
//  pcOut         out  32  to IF/ID: fetched address + 4
//  instOut       out  32  to IF/ID: fetched instruction
//  validOut      out  1   to IF/ID: instOut holds a live instruction
//  timeoutErr    out  1   sticky: no response within MAX_LAT cycles
// BEHAVIOUR
//  Reset (rst=0 at posedge): pc<=RESET_PC, state<=IDLE, pcOut/instOut<=0, validOut<=0, timeoutErr<=0.
//   imemReq=0 while rst=0. The memory shares rst, so no stale response survives reset.
//  FSM states: IDLE, WAIT, DROP.
//  IDLE: imemReq=!freeze & !branchTaken, imemAddr=pc; on issue -> WAIT, fetchAddr<=pc.
//  WAIT, imemRvalid & !freeze: instOut<=imemRdata, pcOut<=fetchAddr+4, validOut<=1, pc<=fetchAddr+4.
//   The next request for fetchAddr+4 issues in the same cycle (stays WAIT). Throughput = 1 instr per latency.
//  WAIT, imemRvalid & freeze: outputs hold; see CONFIGURATION.
//  WAIT, latency counter reaches MAX_LAT: timeoutErr<=1, -> IDLE (pc unchanged, refetch).
//  freeze (no branch): pcOut/instOut/validOut hold their values; pc holds.
//  branchTaken has priority over freeze and rvalid:
//   pc<=branchAddr, validOut<=0, instOut<=32'h0. Any buffered word is discarded. No request that cycle.
//   Branch in WAIT without rvalid -> DROP. Branch in WAIT with rvalid -> word discarded, -> IDLE.
//  DROP: the next imemRvalid is discarded, then -> IDLE. branchTaken in DROP updates pc only.
//  Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
// CONFIGURATION
//  IF_SKID_BUF_EN defined:
//   A 1-entry buffer captures a response that arrives under freeze; state -> IDLE_BUF.
//   On freeze release the buffered word loads IF/ID with zero memory latency.
//  IF_SKID_BUF_EN undefined:
//   A response under freeze is dropped and state -> IDLE with pc unchanged.
//   The same address is re-requested after freeze releases.
//  Both builds: the instruction sequence seen by ID is identical; only latency differs.
// STRUCTURE
//  Package if_pkg: FSM state enum; NOP_INST=32'h0; PC_STEP=4; default RESET_PC.
//  Sub-module if_skid_buf (data+valid register, load/drain/clear), instantiated only under IF_SKID_BUF_EN.
//  Top holds the PC, FSM, IF/ID registers and the latency counter.
// TESTING
//  1. Reset, memory latency 1 -> requests to 0,4,8; pcOut 4,8,12 on consecutive response cycles.
//  2. Latency 3, freeze high 5 cycles mid-WAIT -> outputs stable during freeze.
//     No duplicate or skipped instruction afterwards, in both macro builds.
//  3. branchTaken with branchAddr=0x100 while WAIT -> old response dropped.
//     validOut=0, instOut=0, next request addr=0x100.
//  4. branchTaken and imemRvalid in the same cycle -> word discarded, next fetch at target.
//  5. Memory never responds -> timeoutErr=1 after 15 cycles, refetch of the same pc.
//  6. pc=0xFFFF_FFFC fetched -> pcOut=0, next request addr=0.
//  7. rst pulsed low mid-WAIT -> all outputs 0 next cycle, first request at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared FSM type and constants for the fetch stage.
// IDLE_BUF is only reachable when IF_SKID_BUF_EN is defined.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    DROP     = 2'd2,
    IDLE_BUF = 2'd3
  } ifState_e;

  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] nextPc(
    input logic [31:0] pc
  );
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding register for a fetched word.
// Clear and drain both win over load in the same cycle.
module if_skid_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        valid
);

  // capture on load, empty on drain or clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid   <= 1'b0;
      dataOut <= NOP_INST;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      dataOut <= dataIn;
    end
  end

endmodule

// File: rtl/stage_if_fetch.sv
// stage_if_fetch: PC owner, imem request FSM and IF/ID register.
// Optional IF_SKID_BUF_EN keeps a word that lands under freeze.
module stage_if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          MAX_LAT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic [31:0] pcOut,
  output logic [31:0] instOut,
  output logic        validOut,
  output logic        timeoutErr
);

  localparam int LW = $clog2(MAX_LAT + 1);
  localparam logic [LW-1:0] LAT_ONE = LW'(1);
  localparam logic [LW-1:0] LAT_MAX = LW'(MAX_LAT);

  ifState_e      state;
  ifState_e      stateNext;
  logic [31:0]   pc;
  logic [31:0]   pcNext;
  logic [31:0]   fetchAddr;
  logic [31:0]   fetchNext;
  logic [31:0]   stepAddr;
  logic [LW-1:0] lat;
  logic [LW-1:0] latNext;
  logic [31:0]   pcOutNext;
  logic [31:0]   instNext;
  logic          validNext;
  logic          errNext;
  logic          reqRaw;

  assign stepAddr = nextPc(fetchAddr);
  assign imemReq  = rst & reqRaw;

`ifdef IF_SKID_BUF_EN
  logic        bufLoad;
  logic        bufDrain;
  logic        bufClear;
  logic        bufValid;
  logic [31:0] bufData;

  if_skid_buf uBuf (
    .clk     (clk),
    .rst     (rst),
    .load    (bufLoad),
    .drain   (bufDrain),
    .clear   (bufClear),
    .dataIn  (imemRdata),
    .dataOut (bufData),
    .valid   (bufValid)
  );
`endif

  // next-state, request and IF/ID update decode
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    fetchNext = fetchAddr;
    latNext   = lat;
    pcOutNext = pcOut;
    instNext  = instOut;
    validNext = freeze & validOut;
    errNext   = timeoutErr;
    reqRaw    = 1'b0;
    imemAddr  = pc;
`ifdef IF_SKID_BUF_EN
    bufLoad  = 1'b0;
    bufDrain = 1'b0;
    bufClear = 1'b0;
`endif
    if (branchTaken) begin
      pcNext    = branchAddr;
      validNext = 1'b0;
      instNext  = NOP_INST;
`ifdef IF_SKID_BUF_EN
      bufClear = 1'b1;
`endif
      unique case (state)
        WAIT:    stateNext = imemRvalid ? IDLE : DROP;
        DROP:    stateNext = imemRvalid ? IDLE : DROP;
        default: stateNext = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (!freeze) begin
            reqRaw    = 1'b1;
            fetchNext = pc;
            latNext   = LAT_ONE;
            stateNext = WAIT;
          end
        end
        WAIT: begin
          if (imemRvalid && !freeze) begin
            pcOutNext = stepAddr;
            instNext  = imemRdata;
            validNext = 1'b1;
            pcNext    = stepAddr;
            fetchNext = stepAddr;
            reqRaw    = 1'b1;
            imemAddr  = stepAddr;
            latNext   = LAT_ONE;
          end else if (imemRvalid) begin
`ifdef IF_SKID_BUF_EN
            bufLoad   = 1'b1;
            stateNext = IDLE_BUF;
`else
            stateNext = IDLE;
`endif
          end else if (lat == LAT_MAX) begin
            errNext   = 1'b1;
            stateNext = IDLE;
          end else begin
            latNext = lat + LAT_ONE;
          end
        end
        DROP: begin
          if (imemRvalid) begin
            stateNext = IDLE;
          end else if (lat == LAT_MAX) begin
            errNext   = 1'b1;
            stateNext = IDLE;
          end else begin
            latNext = lat + LAT_ONE;
          end
        end
        IDLE_BUF: begin
`ifdef IF_SKID_BUF_EN
          if (!bufValid) begin
            stateNext = IDLE;
          end else if (!freeze) begin
            pcOutNext = stepAddr;
            instNext  = bufData;
            validNext = 1'b1;
            pcNext    = stepAddr;
            fetchNext = stepAddr;
            reqRaw    = 1'b1;
            imemAddr  = stepAddr;
            latNext   = LAT_ONE;
            bufDrain  = 1'b1;
            stateNext = WAIT;
          end
`else
          stateNext = IDLE;
`endif
        end
      endcase
    end
  end

  // state, PC, watchdog and IF/ID registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      fetchAddr  <= RESET_PC;
      lat        <= '0;
      pcOut      <= '0;
      instOut    <= NOP_INST;
      validOut   <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      fetchAddr  <= fetchNext;
      lat        <= latNext;
      pcOut      <= pcOutNext;
      instOut    <= instNext;
      validOut   <= validNext;
      timeoutErr <= errNext;
    end
  end

endmodule

// File: tb/tb_stage_if_fetch.sv
// tb_stage_if_fetch: random + directed bench with memory model
// and an expected-instruction-stream scoreboard.
module tb_stage_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MAXL   = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddr = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic [31:0] pcOut;
  logic [31:0] instOut;
  logic        validOut;
  logic        timeoutErr;

  stage_if_fetch #(
    .RESET_PC (RST_PC),
    .MAX_LAT  (MAXL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branchTaken (branchTaken),
    .branchAddr  (branchAddr),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemRvalid  (imemRvalid),
    .imemRdata   (imemRdata),
    .pcOut       (pcOut),
    .instOut     (instOut),
    .validOut    (validOut),
    .timeoutErr  (timeoutErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t       sb[$];
  logic [31:0] reqLog[$];
  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  logic [31:0] nextAddr = RST_PC;
  bit          lastFreeze = 1'b0;
  bit          lastBranch = 1'b0;
  bit          lastRst = 1'b0;
  bit          chkNoErr = 1'b1;
  bit          reqNow = 1'b0;
  bit          memPend = 1'b0;
  bit          memNever = 1'b0;
  logic [31:0] memAddr = 32'h0;
  int          memRemain = 0;
  int          latMin = 1;
  int          latMax = 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // keep a window of the sequence ID should see
  task automatic topUp();
    while (sb.size() < 8) begin
      sb.push_back('{pc: nextAddr + 32'd4, inst: memWord(nextAddr)});
      nextAddr = nextAddr + 32'd4;
    end
  endtask

  // one clock: memory response, inputs, model update, request capture
  task automatic step(input bit f, input bit b,
                      input logic [31:0] ba, input bit r);
    @(negedge clk);
    #1;
    imemRvalid = 1'b0;
    imemRdata  = 32'h0;
    if (memPend) begin
      memRemain--;
      if (memRemain <= 0) begin
        imemRvalid = 1'b1;
        imemRdata  = memWord(memAddr);
        memPend    = 1'b0;
      end
    end
    rst         = r;
    freeze      = f;
    branchTaken = b;
    branchAddr  = ba;
    lastFreeze  = f;
    lastBranch  = b;
    lastRst     = r;
    if (!r) begin
      imemRvalid = 1'b0;
      imemRdata  = 32'h0;
      memPend    = 1'b0;
      sb.delete();
      nextAddr = RST_PC;
      chkNoErr = 1'b1;
    end else if (b) begin
      sb.delete();
      nextAddr = ba;
    end
    topUp();
    #3;
    reqNow = imemReq;
    if (!r) chk("req_in_reset", 32'(imemReq), 32'd0);
    if (imemReq) begin
      reqLog.push_back(imemAddr);
      chk("req_overlap", 32'(memPend), 32'd0);
      if (!memNever) begin
        memPend   = 1'b1;
        memAddr   = imemAddr;
        memRemain = int'($urandom_range(latMax, latMin));
      end
    end
  endtask

  task automatic runUntilReq(input string nm);
    int n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end while (!reqNow && n < 40);
    chk(nm, 32'(reqNow), 32'd1);
  endtask

  // monitor: reset, branch-kill, freeze-hold and in-order delivery
  initial begin
    logic [31:0] pPc;
    logic [31:0] pInst;
    logic        pV;
    pPc = 32'h0;
    pInst = 32'h0;
    pV = 1'b0;
    forever begin
      @(negedge clk);
      if (!lastRst) begin
        chk("rst_pcOut", pcOut, 32'h0);
        chk("rst_instOut", instOut, 32'h0);
        chk("rst_validOut", 32'(validOut), 32'd0);
        chk("rst_timeoutErr", 32'(timeoutErr), 32'd0);
      end else if (lastBranch) begin
        chk("br_validOut", 32'(validOut), 32'd0);
        chk("br_instOut", instOut, 32'h0);
      end else if (lastFreeze) begin
        chk("hold_pcOut", pcOut, pPc);
        chk("hold_instOut", instOut, pInst);
        chk("hold_validOut", 32'(validOut), 32'(pV));
      end else if (validOut) begin
        if (sb.size() == 0) begin
          chk("extra_delivery", 32'(sb.size()), 32'd1);
        end else begin
          item_t e;
          e = sb.pop_front();
          chk("deliv_pcOut", pcOut, e.pc);
          chk("deliv_instOut", instOut, e.inst);
          delivered++;
        end
      end
      if (lastRst && chkNoErr)
        chk("no_timeoutErr", 32'(timeoutErr), 32'd0);
      pPc = pcOut;
      pInst = instOut;
      pV = validOut;
    end
  end

  initial begin
    int d0;
    int n;
    int fb;
    logic [31:0] p0;

    // reset, latency 1: back-to-back fetch 0,4,8
    latMin = 1;
    latMax = 1;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    reqLog.delete();
    d0 = delivered;
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_req0", reqLog[0], 32'h0);
    chk("t1_req1", reqLog[1], 32'h4);
    chk("t1_req2", reqLog[2], 32'h8);
    chk("t1_deliv", 32'(delivered - d0), 32'd6);

    // latency 3, freeze 5 cycles while waiting
    latMin = 3;
    latMax = 3;
    runUntilReq("t2_req");
    d0 = delivered;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_progress", 32'(delivered > d0), 32'd1);

    // branch to 0x100 while a response is outstanding
    runUntilReq("t3_req");
    step(1'b0, 1'b1, 32'h100, 1'b1);
    chk("t3_noreq", 32'(reqNow), 32'd0);
    reqLog.delete();
    runUntilReq("t3_req2");
    chk("t3_addr", reqLog[0], 32'h100);

    // branch in the same cycle as the response
    latMin = 2;
    latMax = 2;
    runUntilReq("t4_req");
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    reqLog.delete();
    runUntilReq("t4_req2");
    chk("t4_addr", reqLog[0], 32'h200);

    // address wrap at the top of memory
    latMin = 1;
    latMax = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    reqLog.delete();
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_cnt", 32'(reqLog.size() >= 3), 32'd1);
    if (reqLog.size() >= 3) begin
      chk("t6_req0", reqLog[0], 32'hFFFF_FFF8);
      chk("t6_req1", reqLog[1], 32'hFFFF_FFFC);
      chk("t6_req2", reqLog[2], 32'h0);
    end

    // randomized freeze / branch / latency
    fb = 0;
    for (int i = 0; i < 3000; i++) begin
      bit f;
      bit b;
      logic [31:0] a;
      if (i % 500 == 0) begin
        latMin = 1;
        latMax = (i % 1000 == 0) ? MAXL : 6;
      end
      if (fb > 0) begin
        f = 1'b1;
        fb--;
      end else begin
        f = 1'b0;
        if ($urandom_range(0, 7) == 0) fb = int'($urandom_range(1, 6));
      end
      b = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0, 1:    a = $urandom & 32'h0000_0FFC;
        2:       a = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        default: a = $urandom & ~32'h3;
      endcase
      step(f, b, a, 1'b1);
    end

    // memory never answers: watchdog then refetch
    latMin = 2;
    latMax = 2;
    repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1);
    chkNoErr = 1'b0;
    memNever = 1'b1;
    reqLog.delete();
    runUntilReq("t5_req");
    p0 = reqLog[0];
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end while (!timeoutErr && n < 40);
    chk("t5_cycles", 32'(n), 32'd16);
    chk("t5_reqcnt", 32'(reqLog.size()), 32'd2);
    if (reqLog.size() >= 2) chk("t5_refetch", reqLog[1], p0);

    // reset pulse in the middle of a wait
    memNever = 1'b0;
    latMin = 5;
    latMax = 5;
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    reqLog.delete();
    runUntilReq("t7_req");
    chk("t7_addr", reqLog[0], RST_PC);

    latMin = 1;
    latMax = 4;
    repeat (200) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("total_deliv", 32'(delivered > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
